// File: rtl/lfsr_checker.sv
// Receive-side PRBS checker: self-synchronises a shadow LFSR on the incoming
// bitstream, declares lock after a clean run and counts mismatches while locked.
module lfsr_checker #(
    parameter int LFSRSIZE = 8,
    parameter int LOCKCNT  = 16,
    parameter int LOSSCNT  = 4,
    parameter int CNTW     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LFSRSIZE-1:0] taps,
    input  logic                in_valid,
    input  logic                in_bit,
    input  logic                clr_count,
    output logic                locked,
    output logic                err,
    output logic [CNTW-1:0]     err_count
);

    localparam int FW = $clog2(LFSRSIZE + 1);
    localparam int RW = $clog2(LOCKCNT + 1);
    localparam int MW = $clog2(LOSSCNT + 1);
    localparam logic [FW-1:0] FILL_LAST = FW'(LFSRSIZE - 1);
    localparam logic [RW-1:0] RUN_LAST  = RW'(LOCKCNT - 1);
    localparam logic [MW-1:0] MISS_LAST = MW'(LOSSCNT - 1);

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    function automatic logic [LFSRSIZE-1:0] shift_in(input logic [LFSRSIZE-1:0] sh,
                                                     input logic b);
        return {sh[LFSRSIZE-2:0], b};
    endfunction

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (v == {CNTW{1'b1}}) ? v : v + {{(CNTW-1){1'b0}}, 1'b1};
    endfunction

    state_t                state_r, state_s;
    logic [LFSRSIZE-1:0]   shadow_r, shadow_s;
    logic [LFSRSIZE-1:0]   oldtaps_r;
    logic [FW-1:0]         fill_r, fill_s;
    logic [RW-1:0]         run_r, run_s;
    logic [MW-1:0]         miss_r, miss_s;
    logic                  err_s;
    logic [CNTW-1:0]       cnt_s;
    logic                  pred_s;
    logic                  match_s;

    assign pred_s  = ^(shadow_r & taps);
    assign match_s = (in_bit == pred_s);

    // Next-state, shadow shift and counter updates for one received bit.
    always_comb begin
        state_s  = state_r;
        shadow_s = shadow_r;
        fill_s   = fill_r;
        run_s    = run_r;
        miss_s   = miss_r;
        err_s    = 1'b0;
        cnt_s    = clr_count ? {CNTW{1'b0}} : err_count;

        // A tap change invalidates the shadow history; the bit this cycle is dropped.
        if (taps != oldtaps_r) begin
            state_s = ST_SEED;
            fill_s  = {FW{1'b0}};
            run_s   = {RW{1'b0}};
            miss_s  = {MW{1'b0}};
        end else if (in_valid) begin
            case (state_r)
                ST_SEED: begin
                    shadow_s = shift_in(shadow_r, in_bit);
                    if (fill_r == FILL_LAST) begin
                        state_s = ST_HUNT;
                        fill_s  = {FW{1'b0}};
                        run_s   = {RW{1'b0}};
                    end else begin
                        fill_s = fill_r + {{(FW-1){1'b0}}, 1'b1};
                    end
                end
                ST_HUNT: begin
                    shadow_s = shift_in(shadow_r, in_bit);
                    // An all-zero shadow trivially predicts a stuck-at-0 line.
                    if (match_s && (shadow_r != {LFSRSIZE{1'b0}})) begin
                        if (run_r == RUN_LAST) begin
                            state_s = ST_LOCKED;
                            run_s   = {RW{1'b0}};
                            miss_s  = {MW{1'b0}};
                        end else begin
                            run_s = run_r + {{(RW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        run_s = {RW{1'b0}};
                    end
                end
                ST_LOCKED: begin
                    shadow_s = shift_in(shadow_r, pred_s);
                    if (!match_s) begin
                        err_s = 1'b1;
                        cnt_s = sat_inc(cnt_s);
                        if (miss_r == MISS_LAST) begin
                            state_s = ST_HUNT;
                            run_s   = {RW{1'b0}};
                            miss_s  = {MW{1'b0}};
                        end else begin
                            miss_s = miss_r + {{(MW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        miss_s = {MW{1'b0}};
                    end
                end
                default: begin
                    state_s = ST_SEED;
                    fill_s  = {FW{1'b0}};
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State, shadow register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_SEED;
            shadow_r  <= {LFSRSIZE{1'b0}};
            oldtaps_r <= taps;
            fill_r    <= {FW{1'b0}};
            run_r     <= {RW{1'b0}};
            miss_r    <= {MW{1'b0}};
            locked    <= 1'b0;
            err       <= 1'b0;
            err_count <= {CNTW{1'b0}};
        end else begin
            state_r   <= state_s;
            shadow_r  <= shadow_s;
            oldtaps_r <= taps;
            fill_r    <= fill_s;
            run_r     <= run_s;
            miss_r    <= miss_s;
            locked    <= (state_s == ST_LOCKED);
            err       <= err_s;
            err_count <= cnt_s;
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: a reference LFSR generator drives the checker,
// with table-driven error/clear vectors and hand-written lock/unlock sequences.
module tb_lfsr_checker;

    // Narrow counter so saturation is reachable in a short run.
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    taps;
    logic          in_valid;
    logic          in_bit;
    logic          clr_count;
    logic          locked;
    logic          err;
    logic [CW-1:0] err_count;

    logic [7:0]    gen;
    logic [7:0]    gtaps;
    int            checks = 0;
    int            errors = 0;

    typedef struct {
        logic          valid;
        logic          flip;
        logic          clr;
        logic          exp_locked;
        logic          exp_err;
        logic [CW-1:0] exp_cnt;
    } vec_t;

    vec_t vecs [9];

    lfsr_checker #(.LFSRSIZE(8), .LOCKCNT(16), .LOSSCNT(4), .CNTW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .taps      (taps),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .clr_count (clr_count),
        .locked    (locked),
        .err       (err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic raw(input logic v, input logic b, input logic clr);
        in_valid  = v;
        in_bit    = b;
        clr_count = clr;
        @(negedge clk);
    endtask

    // Advance the reference generator on valid cycles and send its newest bit.
    task automatic step(input logic v, input logic flip, input logic clr);
        logic nb;
        nb = 1'b0;
        if (v) begin
            nb  = ^(gen & gtaps);
            gen = {gen[6:0], nb};
        end else begin
            nb = 1'b0;
        end
        raw(v, nb ^ flip, clr);
    endtask

    initial begin
        int  err_seen;
        int  drop_seen;
        int  vb;
        int  nerr;

        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd2};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd3};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2};

        rst = 1'b1; taps = 8'hB8; gtaps = 8'hB8; gen = 8'h01;
        in_valid = 1'b0; in_bit = 1'b0; clr_count = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_locked", locked, 0);
        chk("reset_err", err, 0);
        chk("reset_cnt", err_count, 0);
        rst = 1'b0;

        // Clean stream: lock after 8 seed + 16 hunt bits.
        for (int i = 1; i <= 24; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (i == 23) chk("lock_not_early", locked, 0);
            if (i == 24) chk("lock_at_24", locked, 1);
        end
        err_seen = 0; drop_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (err) err_seen++;
            if (!locked) drop_seen++;
        end
        chk("clean_err_pulses", err_seen, 0);
        chk("clean_lock_drops", drop_seen, 0);
        chk("clean_cnt", err_count, 0);

        // Single errors, idle cycles, clear-with-error and loss of lock.
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].valid, vecs[i].flip, vecs[i].clr);
            chk($sformatf("vec%0d_locked", i), locked, vecs[i].exp_locked);
            chk($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
            chk($sformatf("vec%0d_cnt", i), err_count, vecs[i].exp_cnt);
        end

        // Relock from HUNT with the shadow intact: 16 clean matches.
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (i == 15) chk("relock_not_early", locked, 0);
            if (i == 16) chk("relock_at_16", locked, 1);
        end
        chk("relock_cnt", err_count, 2);

        // Tap change while locked: drop at once, reseed, half-rate valid.
        taps = 8'h8E; gtaps = 8'h8E;
        step(1'b1, 1'b0, 1'b0);
        chk("tapchg_locked", locked, 0);
        chk("tapchg_cnt", err_count, 2);
        vb = 0;
        for (int i = 0; i < 48; i++) begin
            step((i % 2) == 0, 1'b0, 1'b0);
            if ((i % 2) == 0) begin
                vb++;
                if (vb == 23) chk("tapchg_not_early", locked, 0);
                if (vb == 24) chk("tapchg_relock", locked, 1);
            end
        end
        chk("tapchg_cnt_kept", err_count, 2);

        // Reset in the middle of an error pulse.
        step(1'b1, 1'b1, 1'b0);
        chk("pre_rst_err", err, 1);
        chk("pre_rst_cnt", err_count, 3);
        rst = 1'b1; taps = 8'hB8; gtaps = 8'hB8;
        step(1'b1, 1'b1, 1'b0);
        chk("midrst_locked", locked, 0);
        chk("midrst_err", err, 0);
        chk("midrst_cnt", err_count, 0);
        rst = 1'b0;

        // Stuck-at-0 line never locks.
        err_seen = 0; drop_seen = 0;
        for (int i = 0; i < 200; i++) begin
            raw(1'b1, 1'b0, 1'b0);
            if (err) err_seen++;
            if (locked) drop_seen++;
        end
        chk("stuck0_lock_cycles", drop_seen, 0);
        chk("stuck0_err_pulses", err_seen, 0);
        chk("stuck0_cnt", err_count, 0);

        // Zero taps never lock even on a live stream.
        taps = 8'h00;
        drop_seen = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (locked) drop_seen++;
        end
        chk("taps0_lock_cycles", drop_seen, 0);

        // Relock, then drive the counter into saturation.
        taps = 8'hB8;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 24; i++) step(1'b1, 1'b0, 1'b0);
        chk("sat_prelock", locked, 1);
        nerr = 0; err_seen = 0; drop_seen = 0;
        while (nerr < (1 << CW) + 5) begin
            step(1'b1, 1'b1, 1'b0);
            nerr++;
            if (err) err_seen++;
            if (!locked) drop_seen++;
            if (nerr == (1 << CW) - 1) chk("sat_reach_max", err_count, (1 << CW) - 1);
            if ((nerr % 3) == 0) step(1'b1, 1'b0, 1'b0);
        end
        chk("sat_cnt", err_count, (1 << CW) - 1);
        chk("sat_err_pulses", err_seen, (1 << CW) + 5);
        chk("sat_lock_drops", drop_seen, 0);
        step(1'b1, 1'b1, 1'b1);
        chk("sat_clr_with_err", err_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
